if_id_skid: RTL
===============

Name: if_id_skid

Overview:
Parametrised successor to the plain IF/ID register: sits between fetch and decode. Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is registered, and flush to NOP. Also provides saturating stall and flush counters for performance monitoring. Carries instruction plus address; invalid output slots present a NOP so decode needs no extra gating.

Parameters:
INST_W, 32, instruction width
ADDR_W, 32, instruction address width
NOP_INST, 32'h00000013, value driven on inst_o when no valid entry (addi x0,x0,0)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  fetch presents a beat
in_ready  out  1  stage can accept a beat
inst_i  in  INST_W  fetched instruction
inst_addr_i  in  ADDR_W  fetched instruction address
flush_i  in  1  discard all held and incoming beats (branch/jump redirect)
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode accepts the beat
inst_o  out  INST_W  instruction to decode
inst_addr_o  out  ADDR_W  address to decode
stall_cnt_o  out  CNT_W  cycles with out_valid=1 and out_ready=0
flush_cnt_o  out  CNT_W  cycles with flush_i=1

Behaviour:
- Reset (rst=0 at clock edge): main and skid entries invalid, out_valid=0, inst_o=NOP_INST, inst_addr_o=0, in_ready=1, both counters 0. Beats presented while rst=0 are dropped.
- accept = in_valid & in_ready; deliver = out_valid & out_ready.
- out_valid = main_valid. inst_o/inst_addr_o = main entry when main_valid, else NOP_INST / 0. Outputs come straight from registers, with no combinational path from inputs.
- SKID=1 states: EMPTY (no entries), ONE (main only), FULL (main+skid). in_ready = registered (state != FULL).
  - EMPTY: accept -> ONE, beat into main.
  - ONE: accept & deliver -> ONE, main replaced. Accept & !deliver -> FULL, beat into skid. !accept & deliver -> EMPTY. Otherwise hold.
  - FULL: deliver -> ONE, skid moves to main. Otherwise hold. No accept is possible.
- SKID=0: only EMPTY/ONE. in_ready = !main_valid | out_ready (combinational). Transitions as above, minus FULL.
- Latency: beat accepted in cycle N appears on outputs in cycle N+1 (empty stage). Order strictly preserved. No beat duplicated or lost except by flush.
- Flush has highest priority. The next state is EMPTY, both entries are invalidated, and outputs become NOP_INST / 0 / out_valid=0 the next cycle.
  - A beat handshaken in the flush cycle is consumed from upstream but discarded.
  - in_ready is not gated by flush_i.
  - A deliver in the flush cycle still counts as delivered.
- Simultaneous flush and rst=0: reset wins, and counters clear.
- Holding: while !deliver the main entry and outputs stay bit-stable.
- Counters: +1 per qualifying cycle, saturate at all-ones (no wrap). flush_cnt counts every cycle with flush_i=1, including when empty.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release with in_valid=0 -> out_valid=0, inst_o=32'h00000013, inst_addr_o=0, in_ready=1, counters 0.
- Streaming: out_ready=1, feed inst 0x00500093/0x00A00113/0x002081B3 at addr 0x0/0x4/0x8 back-to-back -> each appears one cycle later in order, in_ready stays 1, stall_cnt=0.
- Backpressure/skid (SKID=1): out_ready=0 while feeding addrs 0x10,0x14,0x18 -> 0x10 on outputs, 0x14 held in skid, in_ready=0 after second accept, 0x18 not accepted. stall_cnt increments each stalled cycle. Raising out_ready then delivers 0x10,0x14,0x18 in order.
- Flush in FULL: state FULL (0x20 main, 0x24 skid), flush_i=1 with in_valid=1 addr 0x28 -> next cycle out_valid=0, inst_o=NOP_INST, in_ready=1, 0x28 never appears, flush_cnt=1. Next beat 0x100 arrives normally.
- SKID=0 build: out_ready toggles 1,0,1 while streaming -> in_ready equals !main_valid|out_ready each cycle, no beat lost or duplicated.
- Counter saturation (CNT_W=4): hold stall for 20 cycles -> stall_cnt_o stops at 4'hF. Reset mid-stall -> counter 0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID pipeline register with valid/ready handshake, skid buffer, flush and perf counters
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   fetch-side handshake; inst_i, inst_addr_i carry the beat
//   flush_i             drop every held and incoming beat (redirect)
//   out_valid/out_ready decode-side handshake; inst_o, inst_addr_o carry the beat
//   stall_cnt_o         saturating count of cycles with out_valid=1 and out_ready=0
//   flush_cnt_o         saturating count of cycles with flush_i=1
module if_id_skid #(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid;
  logic [INST_W-1:0] main_inst;
  logic [ADDR_W-1:0] main_addr;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_addr;
  logic              in_ready_r;
  logic              accept;
  logic              deliver;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // With the skid entry present, in_ready only needs to know whether the
  // skid slot will be free next cycle, so it can come from a flop.
  assign in_ready = SKID ? in_ready_r : (!main_valid | out_ready);

  assign accept  = in_valid & in_ready;
  assign deliver = main_valid & out_ready;

  // The main entry registers are reloaded with NOP/0 whenever the entry
  // goes empty, so the outputs are driven straight from flops.
  assign out_valid   = main_valid;
  assign inst_o      = main_inst;
  assign inst_addr_o = main_addr;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_inst  <= NOP_INST;
      main_addr  <= '0;
      skid_valid <= 1'b0;
      skid_inst  <= NOP_INST;
      skid_addr  <= '0;
      in_ready_r <= 1'b1;
    end else if (flush_i) begin
      // Any beat handshaken this cycle is consumed upstream and dropped here.
      main_valid <= 1'b0;
      main_inst  <= NOP_INST;
      main_addr  <= '0;
      skid_valid <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (skid_valid) begin
      // Full: in_ready is low, so only a delivery can move things along.
      if (deliver) begin
        main_inst  <= skid_inst;
        main_addr  <= skid_addr;
        skid_valid <= 1'b0;
        in_ready_r <= 1'b1;
      end
    end else if (main_valid) begin
      if (accept && deliver) begin
        main_inst <= inst_i;
        main_addr <= inst_addr_i;
      end else if (accept) begin
        // Only reachable with SKID=1; with SKID=0 in_ready requires out_ready here.
        skid_inst  <= inst_i;
        skid_addr  <= inst_addr_i;
        skid_valid <= 1'b1;
        in_ready_r <= 1'b0;
      end else if (deliver) begin
        main_valid <= 1'b0;
        main_inst  <= NOP_INST;
        main_addr  <= '0;
      end
    end else if (accept) begin
      main_valid <= 1'b1;
      main_inst  <= inst_i;
      main_addr  <= inst_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_i && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
